// File: rtl/mod_div_seq.sv
// mod_div_seq: sequential modular divider r = a * b^-1 mod P (binary extended Euclid)
// Ports: clk, rst_n (async, active-low);
//        in_valid/in_ready with operands a, b (sampled only on acceptance);
//        out_valid/out_ready with result r and div_zero (set when b==0, r forced to 0).
// Invariants while running: x1*b == a*u and x2*b == a*v (mod P); x1, x2 stay in [0,P).
module mod_div_seq #(
  parameter int DATAWIDTH = 4,
  parameter int P = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] r,
  output logic                 div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [DATAWIDTH-1:0] PN = DATAWIDTH'(P);
  localparam logic [DATAWIDTH:0] PX = {1'b0, PN};
  localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);
  state_t state, state_nxt;
  logic [DATAWIDTH-1:0] u, v, x1, x2, u_nxt, v_nxt, x1_nxt, x2_nxt, r_nxt;
  logic dz_nxt;
  // x/2 mod P: odd values get P added first (one extra bit) so the shift is exact
  function automatic logic [DATAWIDTH-1:0] half(input logic [DATAWIDTH-1:0] x);
    return DATAWIDTH'(({1'b0, x} + (x[0] ? PX : '0)) >> 1);
  endfunction
  // (x-y) mod P: a borrow out of the extra bit means add P back
  function automatic logic [DATAWIDTH-1:0] msub(input logic [DATAWIDTH-1:0] x,
                                                input logic [DATAWIDTH-1:0] y);
    logic [DATAWIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    return DATAWIDTH'(d + (d[DATAWIDTH] ? PX : '0));
  endfunction
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      u        <= '0;
      v        <= '0;
      x1       <= '0;
      x2       <= '0;
      r        <= '0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      u        <= u_nxt;
      v        <= v_nxt;
      x1       <= x1_nxt;
      x2       <= x2_nxt;
      r        <= r_nxt;
      div_zero <= dz_nxt;
    end
  always_comb begin
    state_nxt = state;
    u_nxt     = u;
    v_nxt     = v;
    x1_nxt    = x1;
    x2_nxt    = x2;
    r_nxt     = r;
    dz_nxt    = div_zero;
    case (state)
      IDLE:
        if (in_valid) begin
          if (b == '0) begin
            r_nxt     = '0;
            dz_nxt    = 1'b1;
            state_nxt = DONE;
          end else begin
            u_nxt     = b;
            v_nxt     = PN;
            x1_nxt    = a;
            x2_nxt    = '0;
            dz_nxt    = 1'b0;
            state_nxt = RUN;
          end
        end
      RUN:
        if (u == ONE) begin
          r_nxt     = x1;
          state_nxt = DONE;
        end else if (v == ONE) begin
          r_nxt     = x2;
          state_nxt = DONE;
        end else if (!u[0]) begin
          u_nxt  = u >> 1;
          x1_nxt = half(x1);
        end else if (!v[0]) begin
          v_nxt  = v >> 1;
          x2_nxt = half(x2);
        end else if (u >= v) begin
          u_nxt  = u - v;
          x1_nxt = msub(x1, x2);
        end else begin
          v_nxt  = v - u;
          x2_nxt = msub(x2, x1);
        end
      DONE: state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule
